// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_state_e : responder FSM states
//   SIZE_WORD / SIZE_BYTE : encoding of the req_byte_i access-size bit
//   lane_en()    : byte-lane write enables for an access of a given size/offset
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  function automatic logic [3:0] lane_en(input logic is_byte, input logic [1:0] addr);
    if (is_byte == SIZE_BYTE) lane_en = 4'b0001 << addr;
    else                      lane_en = 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are not reset.
// Ports:
//   clk   : clock, rising edge
//   we    : byte-lane write enables (lane k = wdata[8k+7:8k])
//   waddr : word write address
//   wdata : write data
//   raddr : word read address
//   rdata : read data, registered (old contents on a same-edge write)
module dmem_array #(
  parameter int DW  = 32,
  parameter int WAW = 10
) (
  input  logic           clk,
  input  logic [3:0]     we,
  input  logic [WAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [WAW-1:0] raddr,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [2**WAW];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data load/store port. One request at a
// time is accepted over valid/ready, executed against dmem_array, and answered
// after LATENCY wait cycles with read data and an error flag.
// Build option: define DMEM_BYTE_SEXT_EN to sign-extend byte loads
// (default build zero-extends them).
// Ports:
//   clk, rst                  : clock; asynchronous active-low reset
//   req_valid_i / req_ready_o : request handshake
//   req_we_i, req_byte_i      : store/load, byte/word
//   req_addr_i, req_wdata_i   : byte address, store data (byte store uses [7:0])
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_rdata_o, rsp_err_o    : load data (0 for stores/errors), error flag
//
// state | meaning
// IDLE  | ready for a request (after the first clock out of reset)
// WAIT  | counting down latency; cnt==0 moves on, store commits on that edge
// RESP  | first cycle loads the response regs, then hold until rsp_ready_i
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 12,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic          req_byte_i,
  input  logic [DW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o
);

  dmem_state_e   state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          started;
  logic          accept, enter_resp;

  logic          lat_we, lat_byte;
  logic [DW-1:0] lat_addr, lat_wdata;
  logic          cur_we, cur_byte, cur_err;
  logic [DW-1:0] cur_addr, cur_wdata;

  logic [3:0]    arr_we;
  logic [DW-1:0] arr_wdata, arr_rdata, load_data;
  logic [7:0]    lane;

  logic          rsp_valid_q, rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;

  assign req_ready_o = (state == IDLE) && started;
  assign accept      = req_valid_i && req_ready_o;

  // With zero latency RESP is entered on the accept edge itself, so the array
  // must see the incoming request rather than the not-yet-latched copy.
  assign cur_we    = (state == IDLE) ? req_we_i    : lat_we;
  assign cur_byte  = (state == IDLE) ? req_byte_i  : lat_byte;
  assign cur_addr  = (state == IDLE) ? req_addr_i  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata_i : lat_wdata;

  assign cur_err = ((cur_byte == SIZE_WORD) && (cur_addr[1:0] != 2'b00)) ||
                   (cur_addr[DW-1:AW] != '0);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign arr_we    = (enter_resp && cur_we && !cur_err) ? lane_en(cur_byte, cur_addr[1:0]) : 4'b0000;
  assign arr_wdata = (cur_byte == SIZE_BYTE) ? {(DW/8){cur_wdata[7:0]}} : cur_wdata;

  dmem_array #(
    .DW  (DW),
    .WAW (AW - 2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (cur_addr[AW-1:2]),
    .wdata (arr_wdata),
    .raddr (cur_addr[AW-1:2]),
    .rdata (arr_rdata)
  );

  assign lane = arr_rdata[{cur_addr[1:0], 3'b000} +: 8];

`ifdef DMEM_BYTE_SEXT_EN
  assign load_data = (cur_byte == SIZE_BYTE) ? {{(DW-8){lane[7]}}, lane} : arr_rdata;
`else
  assign load_data = (cur_byte == SIZE_BYTE) ? {{(DW-8){1'b0}}, lane} : arr_rdata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      started     <= 1'b0;
      lat_we      <= 1'b0;
      lat_byte    <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      started <= 1'b1;
      if (accept) begin
        lat_we    <= req_we_i;
        lat_byte  <= req_byte_i;
        lat_addr  <= req_addr_i;
        lat_wdata <= req_wdata_i;
      end
      // Array read data is valid during the first RESP cycle; register it so
      // the response stays frozen however long the requester stalls.
      if (state == RESP) begin
        if (!rsp_valid_q) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= cur_err;
          rsp_rdata_q <= (cur_err || cur_we) ? '0 : load_data;
        end else if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [int unsigned];

  always #5 clk = ~clk;

  dmem_responder #(.DW(32), .AW(12), .LATENCY(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_byte_i  (req_byte),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: word-addressed store of 32-bit values, byte lanes by shifting.
  task automatic model_op(input logic we, input logic by, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned idx;
    int          sh;
    logic [31:0] w;
    err = (!by && (addr % 4 != 0)) || (addr >= 32'h1000);
    rd  = 32'h0;
    if (err) return;
    idx = addr / 4;
    sh  = 8 * int'(addr % 4);
    w   = mdl.exists(idx) ? mdl[idx] : 32'h0;
    if (we) begin
      mdl[idx] = by ? ((w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh)) : wd;
    end else if (by) begin
      rd = (w >> sh) & 32'hFF;
`ifdef DMEM_BYTE_SEXT_EN
      if (rd[7]) rd = rd | 32'hFFFF_FF00;
`endif
    end else begin
      rd = w;
    end
  endtask

  // Called at a negedge. Returns the response and the number of edges from
  // the accept edge to the one after which rsp_valid was first seen.
  task automatic xact(input logic we, input logic by, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic err, output int lat);
    int t;
    req_valid = 1'b1; req_we = we; req_byte = by; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    rd = '0; err = 1'b0; lat = -1;
    if (!req_ready) begin
      chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
      return;
    end
    rd  = rsp_rdata;
    err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_hs_ready", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic        by;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

`ifdef DMEM_BYTE_SEXT_EN
  localparam logic [31:0] LB22_EXP = 32'hFFFF_FFAA;
`else
  localparam logic [31:0] LB22_EXP = 32'h0000_00AA;
`endif

  vec_t vecs[12];

  initial begin
    logic [31:0] rd, exp_rd, addr, wd;
    logic        err, exp_err, we, by;
    int          lat, t, r;

    vecs[0]  = '{1'b1, 1'b0, 32'h010,  32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h010,  32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h020,  32'h1122_3344, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h022,  32'h0000_00AA, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h020,  32'h0,         32'h11AA_3344, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h023,  32'h0,         32'h0000_0011, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h022,  32'h0,         LB22_EXP,      1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h000,  32'hCAFE_0001, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h021,  32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h1000, 32'h0000_0005, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h000,  32'h0,         32'hCAFE_0001, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h030,  32'h55AA_55AA, 32'h0,         1'b0};

    // Reset / idle
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'b0, rsp_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_valid", {31'b0, rsp_valid}, 32'd0);

    // Directed vectors
    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].by, vecs[i].addr, vecs[i].wd, 0, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, 32'd3);
    end

    // Backpressure: store request held pending while the load response stalls
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h010;
    chk("bp_ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h1234_5678;
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
    for (int h = 0; h < 5; h++) begin
      chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_err",   {31'b0, rsp_err}, 32'd0);
      chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    chk("bp_ready_back", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_store_taken", {31'b0, req_ready}, 32'd0);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    chk("bp_st_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_st_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    xact(1'b0, 1'b0, 32'h010, 32'h0, 0, rd, err, lat);
    chk("bp_reload", rd, 32'h1234_5678);

    // Reset during WAIT of a store drops it
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h030; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle", {31'b0, req_ready}, 32'd1);
    xact(1'b0, 1'b0, 32'h030, 32'h0, 0, rd, err, lat);
    chk("mid_rst_load", rd, 32'h55AA_55AA);
    chk("mid_rst_err", {31'b0, err}, 32'd0);

    // Random traffic against the model; region 0x100..0x13F initialised first
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model_op(1'b1, 1'b0, 32'h100 + 32'(4 * w), wd, exp_rd, exp_err);
      xact(1'b1, 1'b0, 32'h100 + 32'(4 * w), wd, 0, rd, err, lat);
      chk("init_err", {31'b0, err}, 32'd0);
    end
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      by = 1'($urandom_range(0, 1));
      wd = $urandom;
      r  = int'($urandom_range(0, 9));
      if (r < 7) begin
        addr = by ? 32'h100 + 32'($urandom_range(0, 63))
                  : 32'h100 + 32'(4 * $urandom_range(0, 15));
      end else if (r < 8) begin
        by   = 1'b0;
        addr = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      end else begin
        addr = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
      end
      model_op(we, by, addr, wd, exp_rd, exp_err);
      xact(we, by, addr, wd, int'($urandom_range(0, 3)), rd, err, lat);
      chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      chk($sformatf("rnd%0d_err", n), {31'b0, err}, {31'b0, exp_err});
      chk($sformatf("rnd%0d_lat", n), lat, 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
